// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation-select encoding used by the 1-bit slice
// and by wider ALUs built from ripple-chained slices.
package alu_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_NAND = 3'b110,
      OP_NOR  = 3'b111
   } alu_op_e;

   // True for the two select codes that use the adder and produce a carry.
   function automatic logic is_arith(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage : alu_pkg

// File: rtl/full_adder.sv
// Purely combinational 1-bit full adder.
// Ports:
//   x, y  - addend bits
//   ci    - carry in
//   sum   - x ^ y ^ ci
//   co    - majority(x, y, ci)
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic sum,
   output logic co
);

   assign sum = x ^ y ^ ci;
   assign co  = (x & y) | (x & ci) | (y & ci);

endmodule : full_adder

// File: rtl/one_bit_alu.sv
// 1-bit ALU slice with registered result and carry.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset, clears both outputs
//   a, b     - operand bits
//   cin      - carry/borrow in (arithmetic ops only)
//   s        - operation select (alu_pkg::alu_op_e encoding)
//   aluOut   - registered result bit, one cycle after sampling
//   aluCout  - registered carry-out bit; 0 for logic ops
module one_bit_alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            a,
   input  logic            b,
   input  logic            cin,
   input  logic [OP_W-1:0] s,
   output logic            aluOut,
   output logic            aluCout
);

   logic fa_y;
   logic fa_sum;
   logic fa_co;
   logic out_d;
   logic out_q;
   logic cout_d;
   logic cout_q;

   // Subtract is a + ~b + cin, so only the y operand is inverted.
   assign fa_y = (s == OP_SUB) ? ~b : b;

   full_adder u_fa (
      .x   (a),
      .y   (fa_y),
      .ci  (cin),
      .sum (fa_sum),
      .co  (fa_co)
   );

   // Result/carry select; carry is forced low for every logic op.
   always_comb begin
      out_d  = 1'b0;
      cout_d = 1'b0;
      case (s)
         OP_ADD,
         OP_SUB:  begin
            out_d  = fa_sum;
            cout_d = fa_co;
         end
         OP_AND:  out_d = a & b;
         OP_OR:   out_d = a | b;
         OP_XOR:  out_d = a ^ b;
         OP_XNOR: out_d = ~(a ^ b);
         OP_NAND: out_d = ~(a & b);
         OP_NOR:  out_d = ~(a | b);
      endcase
   end

   // Output register; the only state in the slice.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q  <= 1'b0;
         cout_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         cout_q <= cout_d;
      end
   end

   assign aluOut  = out_q;
   assign aluCout = cout_q;

endmodule : one_bit_alu

// File: tb/tb_one_bit_alu.sv
// Scoreboard bench for one_bit_alu: driver pushes hand-computed expected
// {aluCout, aluOut} at the stimulus edge, monitor pops after each capture edge.
module tb_one_bit_alu;
   import alu_pkg::*;

   logic            clk;
   logic            rst;
   logic            a;
   logic            b;
   logic            cin;
   logic [OP_W-1:0] s;
   logic            aluOut;
   logic            aluCout;

   typedef struct {
      logic [1:0] exp;   // {aluCout, aluOut}
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;

   one_bit_alu dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .s       (s),
      .aluOut  (aluOut),
      .aluCout (aluCout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_now(input string name, input logic [1:0] exp);
      tests_run++;
      if ({aluCout, aluOut} !== exp) begin
         tests_failed++;
         $display("FAIL %s: got {cout,out}=%b expected %b at %0t", name, {aluCout, aluOut}, exp, $time);
      end
   endtask

   // Apply inputs on the falling edge; result is expected after the next rising edge.
   task automatic drive(input logic ia, input logic ib, input logic ic,
                        input logic [2:0] is, input logic [1:0] exp, input string name);
      exp_t e;
      @(negedge clk);
      a = ia; b = ib; cin = ic; s = is;
      e.exp = exp; e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: every capture edge presents a new output while out of reset.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_now(e.name, e.exp);
         end
      end
   end

   initial begin
      exp_t e;
      rst = 1'b1; a = 1'b1; b = 1'b1; cin = 1'b1; s = 3'b000;
      #1;
      check_now("reset_state", 2'b00);
      @(negedge clk);
      rst = 1'b0;

      // a=b=cin=0, select stepped through every code
      drive(0, 0, 0, 3'b000, 2'b00, "zero_add");
      drive(0, 0, 0, 3'b001, 2'b01, "zero_sub");
      drive(0, 0, 0, 3'b010, 2'b00, "zero_and");
      drive(0, 0, 0, 3'b011, 2'b00, "zero_or");
      drive(0, 0, 0, 3'b100, 2'b00, "zero_xor");
      drive(0, 0, 0, 3'b101, 2'b01, "zero_xnor");
      drive(0, 0, 0, 3'b110, 2'b01, "zero_nand");
      drive(0, 0, 0, 3'b111, 2'b01, "zero_nor");

      // Logic ops with cin=1 must ignore cin and keep carry low
      drive(1, 0, 1, 3'b010, 2'b00, "log_and");
      drive(1, 0, 1, 3'b011, 2'b01, "log_or");
      drive(1, 0, 1, 3'b100, 2'b01, "log_xor");
      drive(1, 0, 1, 3'b101, 2'b00, "log_xnor");
      drive(1, 0, 1, 3'b110, 2'b01, "log_nand");
      drive(1, 0, 1, 3'b111, 2'b00, "log_nor");
      drive(1, 1, 1, 3'b010, 2'b01, "log_and_11");

      // Subtract: a + ~b + cin
      drive(0, 1, 1, 3'b001, 2'b01, "sub_0_1");
      drive(1, 0, 1, 3'b001, 2'b11, "sub_1_0");
      drive(1, 1, 1, 3'b001, 2'b10, "sub_1_1");
      drive(0, 0, 1, 3'b001, 2'b10, "sub_0_0");

      // Add exhaustive: {cout,out} = a+b+cin
      drive(0, 0, 0, 3'b000, 2'b00, "add_000");
      drive(0, 0, 1, 3'b000, 2'b01, "add_001");
      drive(0, 1, 0, 3'b000, 2'b01, "add_010");
      drive(0, 1, 1, 3'b000, 2'b10, "add_011");
      drive(1, 0, 0, 3'b000, 2'b01, "add_100");
      drive(1, 0, 1, 3'b000, 2'b10, "add_101");
      drive(1, 1, 0, 3'b000, 2'b10, "add_110");
      drive(1, 1, 1, 3'b000, 2'b11, "add_111");

      // Reset mid-cycle while outputs are 11
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_now("rst_async", 2'b00);
      @(negedge clk);
      a = 1'b1; b = 1'b1; cin = 1'b1; s = 3'b000;
      @(posedge clk);
      #1;
      check_now("rst_hold_1", 2'b00);
      @(posedge clk);
      #1;
      check_now("rst_hold_2", 2'b00);

      // First edge after release captures normally
      @(negedge clk);
      rst = 1'b0;
      a = 1'b1; b = 1'b1; cin = 1'b0; s = 3'b000;
      e.exp = 2'b10; e.name = "post_rst_add";
      exp_q.push_back(e);

      // Latency: inputs changed just after an edge hold off until the next edge
      drive(0, 0, 0, 3'b000, 2'b00, "lat_base");
      @(posedge clk);
      #2;
      a = 1'b1; b = 1'b1; cin = 1'b0; s = 3'b000;
      e.exp = 2'b10; e.name = "lat_update";
      exp_q.push_back(e);
      @(negedge clk);
      check_now("lat_hold", 2'b00);
      @(posedge clk);
      #2;

      // Select change between edges: only the sampled value matters
      @(negedge clk);
      a = 1'b1; b = 1'b0; cin = 1'b0; s = 3'b010;
      #2;
      s = 3'b011;
      e.exp = 2'b01; e.name = "sel_late";
      exp_q.push_back(e);

      // Drain with a bounded wait
      begin
         int waited = 0;
         while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
         end
         #2;
         tests_run++;
         if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_one_bit_alu
